// File: rtl/booth_operand_seq.sv
// Operand sequencer and result collector for the Booth multiplier: feeds multiplier then
// multiplicand onto the shared data bus, collects the product or flags a timeout.
module booth_operand_seq #(
    parameter int N       = 9,
    parameter int TIMEOUT = 2*N+8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [N-1:0]   req_mplier,
    input  logic [N-1:0]   req_mcand,
    output logic           mul_start,
    output logic [N-1:0]   mul_data,
    input  logic           mul_done,
    input  logic [2*N-1:0] mul_product,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*N-1:0] rsp_product,
    output logic           rsp_err,
    output logic           busy
);

    localparam int CW = $clog2(TIMEOUT+1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT-1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_START, S_LDQ, S_LDP, S_WAIT, S_RESP
    } state_t;

    state_t           r_state;
    logic signed [N-1:0] r_mplier;
    logic signed [N-1:0] r_mcand;
    logic [CW-1:0]    r_cnt;
    logic             r_req_ready;
    logic             r_mul_start;
    logic [N-1:0]     r_mul_data;
    logic             r_rsp_valid;
    logic [2*N-1:0]   r_rsp_product;
    logic             r_rsp_err;
    logic             r_busy;

    // Every output is registered alongside the state so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_mplier      <= '0;
            r_mcand       <= '0;
            r_cnt         <= '0;
            r_req_ready   <= 1'b1;
            r_mul_start   <= 1'b0;
            r_mul_data    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_product <= '0;
            r_rsp_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_mplier    <= req_mplier;
                        r_mcand     <= req_mcand;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    // A done still high from a previous run must clear before a new start.
                    if (!mul_done) begin
                        r_mul_start <= 1'b1;
                        r_mul_data  <= r_mplier;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    r_mul_start <= 1'b0;
                    r_mul_data  <= r_mplier;
                    r_state     <= S_LDQ;
                end
                S_LDQ: begin
                    r_mul_data <= r_mcand;
                    r_state    <= S_LDP;
                end
                S_LDP: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        r_rsp_product <= mul_product;
                        r_rsp_err     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rsp_product <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_mul_data  <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_mul_start <= 1'b0;
                    r_mul_data  <= '0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign mul_start   = r_mul_start;
    assign mul_data    = r_mul_data;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_product = r_rsp_product;
    assign rsp_err     = r_rsp_err;
    assign busy        = r_busy;

endmodule

// File: doc/booth_operand_seq.md
# booth_operand_seq

Operand sequencer and result collector wrapped around the Booth multiplier datapath and control path. Accepts one multiply request (multiplier and multiplicand) over a valid/ready handshake. Time-multiplexes both operands onto the multiplier's shared `data_in` bus in the order its control path loads them, then captures the 2N-bit product on `done`. Returns the product, with a timeout error flag, over a second valid/ready handshake.

## Interface
- `N`, 9: operand width, equal to the multiplier's `N`.
- `TIMEOUT`, 2*N+8: maximum WAIT cycles before the block abandons the operation.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_mplier` in N: signed multiplier (Q operand).
- `req_mcand` in N: signed multiplicand (P operand).
- `mul_start` out 1: start pulse to the multiplier control path.
- `mul_data` out N: drives the multiplier's `data_in`.
- `mul_done` in 1: multiplier `done` level.
- `mul_product` in 2N: multiplier `out`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_product` out 2N: captured signed product.
- `rsp_err` out 1: 1 means a timeout occurred and the product is invalid.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, ARM, START, LDQ, LDP, WAIT, RESP. All transitions occur on the `clk` rising edge.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&`req_ready`: latch `req_mplier` and `req_mcand` into internal registers, go to ARM.
  - `req_*` is ignored in every other state.
- **ARM**
  - If `mul_done`=0, go to START.
  - Otherwise stay in ARM. This prevents starting a multiplier still showing a stale `done`.
- **START**: `mul_start`=1, `mul_data`=mplier. Go to LDQ.
- **LDQ**: `mul_start`=0, `mul_data`=mplier. Go to LDP.
- **LDP**: `mul_data`=mcand. Go to WAIT. Clear the timeout counter.
- **WAIT**
  - `mul_data`=mcand, held.
  - The counter increments once per cycle.
  - If `mul_done`=1: capture `mul_product` into `rsp_product`, set `rsp_err`=0, go to RESP.
  - Else if the counter equals TIMEOUT-1: set `rsp_product`=0 and `rsp_err`=1, go to RESP.
  - If both conditions hold in the same cycle, `mul_done` wins.
- **RESP**
  - `rsp_valid`=1. `rsp_product` and `rsp_err` stay stable until the transfer.
  - On `rsp_ready`: go to IDLE.
- `mul_data`=0 in IDLE and ARM.
- The product passes through unmodified as 2N bits. The block does no sign or width arithmetic.
- The timeout counter is ceil(log2(TIMEOUT+1)) bits wide and saturates; it never wraps.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state goes to IDLE; `req_ready`=1 (decoded from IDLE).
  - `mul_start`=0, `mul_data`=0, `rsp_valid`=0, `rsp_product`=0, `rsp_err`=0, `busy`=0.
  - Operand registers and counter are cleared.
  - No request is accepted while `rst_n` is low.
- All outputs are Moore outputs decoded from the registered state and datapath registers. There are no combinational paths from inputs to outputs.
- Cycle-level sequence, request accepted at edge E0:
  - ARM during E0..E1.
  - START (`mul_start`=1) during E1..E2, assuming `mul_done`=0.
  - LDQ during E2..E3, LDP during E3..E4.
  - WAIT from E4 onward.
- Minimum request-to-response latency: 5 cycles, when `mul_done` is high in the first WAIT cycle.
- Response latency after `mul_done` rises: 1 cycle (`rsp_valid` is high after the capturing edge).
- Throughput: at most one operation in flight. `req_ready`=0 from acceptance until the RESP transfer completes. IDLE is re-entered the cycle after `rsp_ready`.
- Reset mid-operation aborts immediately. A `mul_done` arriving after reset is ignored because the block is in IDLE.

## Test plan
- **Reset values.** Assert `rst_n`=0 asynchronously mid-cycle -> all outputs immediately take their reset values, `req_ready`=1. Release -> no spurious `mul_start`.
- **Basic multiply.** Apply `req_mplier`=0x1FD (-3), `req_mcand`=0x005, with a behavioural multiplier model giving `done` 12 cycles after start -> `mul_data` shows 0x1FD, 0x1FD, 0x005 across START/LDQ/LDP with `mul_start` for one cycle only -> `rsp_valid`=1 with `rsp_product`=0x3FFF1 (-15) and `rsp_err`=0.
- **Response backpressure.** Hold `rsp_ready`=0 for 5 cycles while presenting a second `req_valid` -> `rsp_product` is stable, `req_ready`=0, the second request is not taken. Raise `rsp_ready` -> IDLE next cycle, then the second request is accepted.
- **Timeout.** Model never asserts `mul_done` -> after exactly TIMEOUT=26 WAIT cycles, `rsp_valid`=1 with `rsp_err`=1 and `rsp_product`=0.
- **ARM stall.** Hold `mul_done`=1 at acceptance -> the block stays in ARM with `mul_start`=0. Drop `mul_done` -> START in the next cycle.
- **Done vs. timeout tie.** Raise `mul_done` in the same cycle the counter hits TIMEOUT-1 -> `rsp_err`=0 and the product is captured.
